// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM encoding,
// default device address and ACK/NACK levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX_BYTE,
    ST_TX_MACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h4B;
  localparam logic       I2C_ACK        = 1'b0;
  localparam logic       I2C_NACK       = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus
// SCL edge and START/STOP condition strobes.
module i2c_line_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1] is the synchronized value, [2] its previous sample
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2]
                    & ~sda_q[1] & sda_q[2];
  assign stop_o     = scl_q[1] & scl_q[2]
                    & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// I2C slave serving a 16-bit temperature
// snapshot; write data is ACKed and dropped.
module i2c_temp_sensor_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR
) (
  input  logic       clk_200kHz,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       SDA_dir,
  input  logic [7:0] temp_msb,
  input  logic [7:0] temp_lsb,
  output logic       busy,
  output logic       rd_done
);

  i2c_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] snap_q, snap_d;
  logic        idx_q, idx_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic sda_s, scl_rise, scl_fall;
  logic start_det, stop_det;
  logic [7:0] cur_byte, nxt_byte;

  i2c_line_sync u_sync (
    .clk_i      (clk_200kHz),
    .reset_i    (reset),
    .scl_i      (SCL),
    .sda_i      (SDA),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign SDA     = dir_q ? 1'b0 : 1'bz;
  assign SDA_dir = dir_q;
  assign busy    = busy_q;
  assign rd_done = done_q;

  assign cur_byte = idx_q ? snap_q[7:0] : snap_q[15:8];
  assign nxt_byte = idx_q ? snap_q[15:8] : snap_q[7:0];

  always_ff @(posedge clk_200kHz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      snap_q  <= '0;
      idx_q   <= 1'b0;
      rw_q    <= 1'b0;
      phase_q <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      phase_d = 1'b0;
      dir_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      dir_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shreg_d[7:1] == SLAVE_ADDR) begin
                snap_d  = {temp_msb, temp_lsb};
                busy_d  = 1'b1;
                rw_d    = sda_s;
                phase_d = 1'b0;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end
        // phase 0: first SCL fall pulls low,
        // phase 1: second fall ends the ACK slot
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              dir_d   = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = '0;
              if (rw_q) begin
                idx_d   = 1'b0;
                dir_d   = ~snap_q[15];
                state_d = ST_TX_BYTE;
              end else begin
                dir_d   = 1'b0;
                state_d = ST_RX_BYTE;
              end
            end
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              dir_d   = 1'b0;
              phase_d = 1'b0;
              state_d = ST_TX_MACK;
            end else begin
              cnt_d = cnt_q + 3'd1;
              dir_d = ~cur_byte[3'd6 - cnt_q];
            end
          end
        end
        ST_TX_MACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              phase_d = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            idx_d   = ~idx_q;
            cnt_d   = '0;
            dir_d   = ~nxt_byte[7];
            state_d = ST_TX_BYTE;
          end
        end
        ST_RX_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              phase_d = 1'b0;
              state_d = ST_RX_ACK;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              dir_d   = 1'b1;
              phase_d = 1'b1;
            end else begin
              dir_d   = 1'b0;
              phase_d = 1'b0;
              cnt_d   = '0;
              state_d = ST_RX_BYTE;
            end
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          dir_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          dir_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_sensor_slave.sv
// Directed bench: bit-banged I2C master
// against the temperature sensor slave.
module tb_i2c_temp_sensor_slave;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] temp_msb = 8'h19;
  logic [7:0] temp_lsb = 8'h80;
  wire        SDA;
  logic       SDA_dir;
  logic       busy;
  logic       rd_done;

  assign SDA = m_low ? 1'b0 : 1'bz;
  pullup (SDA);

  always #5 clk = ~clk;

  i2c_temp_sensor_slave #(
    .SLAVE_ADDR (7'h4B)
  ) dut (
    .clk_200kHz (clk),
    .reset      (reset),
    .SCL        (scl),
    .SDA        (SDA),
    .SDA_dir    (SDA_dir),
    .temp_msb   (temp_msb),
    .temp_lsb   (temp_lsb),
    .busy       (busy),
    .rd_done    (rd_done)
  );

  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  logic dir_seen = 1'b0;
  logic busy_seen = 1'b0;
  logic dir_prev = 1'b0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_done === 1'b1) rd_cnt++;
    if (SDA_dir === 1'b1) dir_seen = 1'b1;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (SDA_dir !== dir_prev)
      chk("dir_scl_low", 16'(scl), 16'd0);
    dir_prev = SDA_dir;
  end

  task automatic bit_x(input logic b,
                       output logic r);
    #Q m_low = ~b;
    #Q scl = 1'b1;
    #Q r = SDA;
    #Q scl = 1'b0;
  endtask

  task automatic start_c;
    m_low = 1'b0;
    scl   = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic stop_c;
    #Q m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d,
                         output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--)
      bit_x(d[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack,
                         output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(mack, r);
  endtask

  logic       ack;
  logic [7:0] d0, d1;
  logic [7:0] exp4 [4];

  initial begin
    exp4[0] = 8'h19;
    exp4[1] = 8'h80;
    exp4[2] = 8'h19;
    exp4[3] = 8'h80;

    repeat (4) @(negedge clk);
    chk("rst_dir", 16'(SDA_dir), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_rd_done", 16'(rd_done), 16'd0);
    reset = 1'b0;
    #(4*Q);

    rd_cnt = 0;
    start_c();
    wr_byte(8'h97, ack);
    chk("rd_addr_ack", 16'(ack), 16'd0);
    chk("rd_busy", 16'(busy), 16'd1);
    rd_byte(1'b0, d0);
    chk("rd_b0", 16'(d0), 16'h19);
    rd_byte(1'b1, d1);
    chk("rd_b1", 16'(d1), 16'h80);
    chk("rd_done_cnt", 16'(rd_cnt), 16'd1);
    stop_c();
    #Q;
    chk("rd_busy_stop", 16'(busy), 16'd0);

    dir_seen  = 1'b0;
    busy_seen = 1'b0;
    start_c();
    wr_byte(8'h91, ack);
    chk("miss_ack", 16'(ack), 16'd1);
    rd_byte(1'b1, d0);
    chk("miss_data", 16'(d0), 16'hFF);
    stop_c();
    #Q;
    chk("miss_dir", 16'(dir_seen), 16'd0);
    chk("miss_busy", 16'(busy_seen), 16'd0);

    start_c();
    wr_byte(8'h97, ack);
    chk("wrap_ack", 16'(ack), 16'd0);
    for (int i = 0; i < 4; i++) begin
      rd_byte(i == 3, d0);
      chk($sformatf("wrap_b%0d", i),
          16'(d0), 16'(exp4[i]));
    end
    stop_c();
    #Q;

    rd_cnt = 0;
    start_c();
    wr_byte(8'h96, ack);
    chk("wr_addr_ack", 16'(ack), 16'd0);
    wr_byte(8'h03, ack);
    chk("wr_data_ack", 16'(ack), 16'd0);
    stop_c();
    #Q;
    chk("wr_rd_done", 16'(rd_cnt), 16'd0);
    chk("wr_busy", 16'(busy), 16'd0);

    start_c();
    wr_byte(8'h97, ack);
    fork
      rd_byte(1'b0, d0);
      begin
        #(12*Q);
        temp_msb = 8'h1A;
      end
    join
    rd_byte(1'b1, d1);
    stop_c();
    #Q;
    chk("snap_b0", 16'(d0), 16'h19);
    chk("snap_b1", 16'(d1), 16'h80);
    start_c();
    wr_byte(8'h97, ack);
    rd_byte(1'b0, d0);
    rd_byte(1'b1, d1);
    stop_c();
    #Q;
    chk("relatch_b0", 16'(d0), 16'h1A);
    chk("relatch_b1", 16'(d1), 16'h80);
    temp_msb = 8'h19;

    start_c();
    wr_byte(8'h97, ack);
    repeat (6) @(negedge clk);
    chk("mid_bit7_low", 16'(SDA_dir), 16'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_dir", 16'(SDA_dir), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 16'(busy), 16'd0);
    stop_c();
    #Q;
    rd_cnt = 0;
    start_c();
    wr_byte(8'h97, ack);
    chk("post_ack", 16'(ack), 16'd0);
    rd_byte(1'b0, d0);
    chk("post_b0", 16'(d0), 16'h19);
    rd_byte(1'b1, d1);
    chk("post_b1", 16'(d1), 16'h80);
    stop_c();
    #Q;
    chk("post_rd_done", 16'(rd_cnt), 16'd1);
    chk("post_busy", 16'(busy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_temp_sensor_slave.md
I2C_TEMP_SENSOR_SLAVE -- requirements
Module: i2c_temp_sensor_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h4B, 7-bit I2C address the block answers.
REQ-002 SHALL have port clk_200kHz, input, 1 bit: sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port SCL, input, 1 bit: I2C clock from the master, nominally 10 kHz.
REQ-005 SHALL have port SDA, inout, 1 bit: I2C data; the block drives only 0 or Z, never 1.
REQ-006 SHALL have port SDA_dir, output, 1 bit: 1 while the block pulls SDA low.
REQ-007 SHALL have port temp_msb, input, 8 bits: temperature MSB to serve.
REQ-008 SHALL have port temp_lsb, input, 8 bits: temperature LSB to serve.
REQ-009 SHALL have port busy, output, 1 bit: high from address match to STOP/START.
REQ-010 SHALL have port rd_done, output, 1 bit: one-cycle pulse when the master NACKs a transmitted byte.

Function
REQ-011 SHALL synchronize SCL and SDA through 2 flops each (reset value 1) and derive rise/fall strobes from the synchronized values.
REQ-012 SHALL detect START as synchronized SDA falling while synchronized SCL is high, and STOP as SDA rising while SCL is high; each detection has priority over every state and applies in any state.
REQ-013 START (incl. repeated START) SHALL go to ADDR with bit counter 0 and SDA released; STOP SHALL go to IDLE with SDA released.
REQ-014 States SHALL be IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_MACK, RX_BYTE, RX_ACK, WAIT_STOP.
REQ-015 ADDR SHALL shift SDA in MSB-first on 8 SCL rising edges; after the 8th, match is addr[7:1]==SLAVE_ADDR.
REQ-016 On mismatch SHALL go to WAIT_STOP without driving SDA.
REQ-017 On match SHALL latch {temp_msb,temp_lsb} into a 16-bit snapshot, set busy, and enter ADDR_ACK.
REQ-018 In ADDR_ACK SHALL pull SDA low from the next SCL falling edge until the following SCL falling edge.
REQ-019 After ADDR_ACK, R/W=1 SHALL enter TX_BYTE with byte index 0; R/W=0 SHALL enter RX_BYTE.
REQ-020 TX_BYTE SHALL present bit 7..0 of the current byte, each updated only on SCL falling edge; bit 1 = released, bit 0 = driven low.
REQ-021 Byte index 0 = snapshot MSB, 1 = snapshot LSB, 2 and above wrap to MSB (index toggles).
REQ-022 After the 8th bit's falling edge SHALL release SDA and enter TX_MACK; master's bit sampled on next SCL rising edge.
REQ-023 Master ACK (0) SHALL advance index and re-enter TX_BYTE; NACK (1) SHALL pulse rd_done and enter WAIT_STOP.
REQ-024 RX_BYTE SHALL sample 8 bits (discarded), then RX_ACK SHALL pull SDA low for one SCL low-high-low period as REQ-018, then return to RX_BYTE.
REQ-025 SDA_dir SHALL change only within 4 clk_200kHz cycles after a synchronized SCL falling edge, never while SCL is high.
REQ-026 Snapshot SHALL not change during a transaction, even if temp_msb/temp_lsb change.

Reset
REQ-027 On reset: state IDLE, SDA_dir 0 (SDA=Z), busy 0, rd_done 0, counters 0, snapshot 0, sync flops 1.
REQ-028 Reset asserted mid-transaction SHALL release SDA on the next clock edge; the block then waits for a new START.

Structure
REQ-029 State encoding, default SLAVE_ADDR and ACK/NACK constants SHALL live in a shared package i2c_pkg.
REQ-030 One sub-module i2c_line_sync (2-flop sync plus edge/START/STOP detect), instantiated once.

Verification
REQ-031 Read 0x97 with temp_msb=8'h19, temp_lsb=8'h80, master ACK then NACK -> address ACK, bytes 0x19, 0x80, one rd_done pulse, busy low after STOP.
REQ-032 Address 0x91 (0x48, read) -> no SDA drive for whole transaction, busy stays 0.
REQ-033 Read with three ACKed bytes then NACK -> bytes 0x19, 0x80, 0x19, 0x80.
REQ-034 Write 0x96 then data 0x03 -> ACK on address and data byte, no rd_done.
REQ-035 Change temp_msb to 8'h1A during byte 0 -> served bytes remain 0x19, 0x80.
REQ-036 Reset during TX_BYTE with SDA low -> SDA_dir 0 next cycle; subsequent full read succeeds.
